// File: rtl/mod7_sched_pkg.sv
// mod7_sched_pkg: shared states, constants and the bit-serial mod-7 step
package mod7_sched_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int MOD = 7;
    localparam int RW  = 3;
    function automatic logic [RW-1:0] mod7_step(input logic [RW-1:0] r, input logic b);
        logic [RW:0] t;
        t = {r, b};
        return (t >= (RW+1)'(MOD)) ? RW'(t - (RW+1)'(MOD)) : t[RW-1:0];
    endfunction
endpackage

// File: rtl/mod7_residue.sv
// mod7_residue: registered residue accumulator, one message bit per enabled cycle
module mod7_residue
    import mod7_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [RW-1:0] residue
);
    always_ff @(posedge clk)
        if (rst || clr) residue <= '0;
        else if (en)    residue <= mod7_step(residue, bit_in);
endmodule

// File: rtl/mod7_sched.sv
// mod7_sched: round-robin front end for a shared serial mod-7 engine (MOD7_SCHED_FIXED_PRIO_EN selects fixed priority)
module mod7_sched
    import mod7_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [2:0]            res_rem,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t          state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]   count;
    logic [IDW-1:0]  gid, gnt, idx;
    logic            gnt_ok, take;
    logic [RW-1:0]   residue;
`ifdef MOD7_SCHED_FIXED_PRIO_EN
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'(k);
            if (req_valid[idx]) begin
                gnt    = idx;
                gnt_ok = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] ptr;
    // Scan from farthest to nearest so the first requester after ptr wins last.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                gnt    = idx;
                gnt_ok = 1'b1;
            end
        end
    end
    always_ff @(posedge clk)
        if (rst)                           ptr <= IDW'(NREQ - 1);
        else if (state == DONE && res_ready) ptr <= gid;
`endif
    assign take = (state == IDLE) && gnt_ok;
    always_comb begin
        req_ready = '0;
        if (take) req_ready[gnt] = 1'b1;
    end
    always_comb begin
        state_nx = take                                   ? SHIFT :
                   (state == SHIFT && count == CW'(1))    ? DONE  :
                   (state == DONE && res_ready)           ? IDLE  : state;
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_ff @(posedge clk)
        if (rst) begin
            shreg <= '0;
            count <= '0;
            gid   <= '0;
        end else if (take) begin
            shreg <= req_data[gnt*WIDTH +: WIDTH];
            count <= CW'(WIDTH);
            gid   <= gnt;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            count <= count - CW'(1);
        end
    mod7_residue u_residue (
        .clk     (clk),
        .rst     (rst),
        .clr     (take),
        .en      (state == SHIFT),
        .bit_in  (shreg[WIDTH-1]),
        .residue (residue)
    );
    assign res_valid = (state == DONE);
    assign res_id    = gid;
    assign res_rem   = res_valid ? residue : 3'd0;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mod7_sched.sv
// tb_mod7_sched: randomized scoreboard bench for mod7_sched against an arithmetic reference model
module tb_mod7_sched;
    localparam int NREQ = 4, WIDTH = 16, IDW = 2, LAT = WIDTH + 1;
    logic                  clk = 1'b0, rst = 1'b1, res_ready = 1'b0;
    logic [NREQ-1:0]       req_valid = '0, req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  res_valid, busy;
    logic [IDW-1:0]        res_id, prev_id = '0;
    logic [2:0]            res_rem, prev_rem = '0;
    logic                  prev_v = 1'b0, prev_r = 1'b0;
    int total = 0, bad = 0, cyc = 0, hs_count = 0, last = NREQ - 1;
    typedef struct {int id; int rem; int c0;} exp_t;
    exp_t q[$];

    mod7_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_rem(res_rem), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference arbitration: first asserted requester after the last one served.
    function automatic int pred(input logic [NREQ-1:0] v, input int lst);
`ifdef MOD7_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        if (rst) begin
            q.delete();
            last   = NREQ - 1;
            prev_v = 1'b0;
        end else begin
            g = pred(req_valid, last);
            if (q.size() == 0) begin
                chk("idle_res_valid", res_valid, 0);
                chk("idle_busy", busy, 0);
                chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
                if (g >= 0) begin
                    q.push_back('{g, int'(req_data[g*WIDTH +: WIDTH]) % 7, cyc});
                    hs_count++;
                end
            end else begin
                chk("busy_ready", req_ready, 0);
                chk("busy", busy, 1);
                if (prev_v && !prev_r) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_id", res_id, prev_id);
                    chk("hold_rem", res_rem, prev_rem);
                end
                if (res_valid) begin
                    if (!prev_v) chk("latency", cyc - q[0].c0, LAT);
                    if (res_ready) begin
                        chk("res_id", res_id, q[0].id);
                        chk("res_rem", res_rem, q[0].rem);
                        last = q[0].id;
                        void'(q.pop_front());
                    end
                end
            end
            prev_v   = res_valid;
            prev_r   = res_ready;
            prev_id  = res_id;
            prev_rem = res_rem;
        end
    end

    task automatic do_op(input int i, input logic [WIDTH-1:0] v);
        bit ok = 0;
        req_data[i*WIDTH +: WIDTH] = v;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready[i];
        end
        if (!ok) chk("timeout_handshake", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int target = hs_count + n;
        for (int k = 0; k < 500 && hs_count < target; k++) @(negedge clk);
        if (hs_count < target) chk("timeout_grants", hs_count, target);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = (q.size() == 0) && !res_valid && !busy;
        end
        if (!ok) chk("timeout_idle", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = res_valid;
        end
        if (!ok) chk("timeout_valid", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int ev[4] = '{65535, 0, 7, 1000};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_rem", res_rem, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        do_op(0, 16'd100);
        wait_idle();
        foreach (ev[i]) begin
            do_op(2, WIDTH'(ev[i]));
            wait_idle();
        end
        for (int i = 0; i < 3; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_valid = 4'b0111;
        wait_hs(6);
        req_valid = '0;
        wait_idle();
        res_ready = 1'b0;
        do_op(1, WIDTH'($urandom));
        wait_valid();
        req_data[3*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_valid[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_hs(1);
        req_valid = '0;
        wait_idle();
        do_op(1, WIDTH'($urandom));
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_data[0 +: WIDTH] = WIDTH'($urandom);
        req_data[3*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_valid = 4'b1001;
        wait_hs(2);
        req_valid = '0;
        wait_idle();
        repeat (600) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            req_data  = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
